ov7670_stream_gen: RTL
======================

Name: ov7670_stream_gen

Overview:
Synthesizable OV7670 sensor emulator that drives the camera-side pixel bus (PCLK, VSYNC, HREF, D[7:0]) with RGB565 test patterns. It is the transmitter counterpart of the capture path. It feeds the capture logic on-board in place of the real sensor, which enables camera-less bring-up of the capture → core → VGA chain. It runs entirely in the clk25 domain.

Parameters:
H_ACTIVE, 640, active pixels per line (multiple of 8)
H_BLANK, 144, blank pixel periods per line (HREF low)
V_ACTIVE, 480, active lines per frame
VSYNC_LINES, 3, lines with VSYNC high
VBP_LINES, 17, blank lines after VSYNC, before first active line
VFP_LINES, 10, blank lines after last active line

Ports:
clk25  in  1  system clock, 25 MHz
rst_n  in  1  asynchronous active-low reset
enable  in  1  frame generation request, sampled at frame boundary only
pattern_sel  in  2  0 color bars, 1 gradient, 2 x+y counter, 3 solid
solid_color  in  16  RGB565 value for pattern 3
cam_pclk  out  1  emulated PCLK = clk25/2, free-running after reset
cam_vsync  out  1  frame sync, active high
cam_href  out  1  line valid, active high
cam_d  out  8  pixel byte
frame_start  out  1  one clk25 pulse when VSYNC rises
busy  out  1  high from VSYNC rise until end of front porch
frame_count  out  16  completed frames, wraps at 0xFFFF→0

Behaviour:
- Reset values: cam_pclk, cam_vsync, cam_href, frame_start, busy = 0; cam_d = 0x00; frame_count = 0; FSM = IDLE.
- cam_pclk toggles every clk25 cycle.
- Define a slot as the clk25 edge where cam_pclk goes 1→0. All other outputs and counters change only on slots. Outputs are therefore stable around each cam_pclk rising edge.
- Each pixel uses 2 byte-slots. Line length = 2*(H_ACTIVE+H_BLANK) slots.
- FSM: IDLE → VSYNC → VBP → ACTIVE → VFP → IDLE/VSYNC.
- IDLE: all sync outputs low. On a slot with enable=1:
  - go to VSYNC;
  - latch pattern_sel and solid_color into shadow registers (fixed for the whole frame);
  - frame_start pulses on that clk25 edge;
  - busy=1.
- VSYNC: cam_vsync=1 for VSYNC_LINES full lines, then VBP.
- VBP: VBP_LINES lines with vsync=0 and href=0, then ACTIVE with y=0.
- ACTIVE: per line, href=1 for the first 2*H_ACTIVE slots, then href=0 for 2*H_BLANK slots.
  - Byte order per pixel: high byte {R5,G6[5:3]}, then low byte {G6[2:0],B5}.
  - After line V_ACTIVE-1 ends, go to VFP.
- cam_d = 0x00 whenever href=0.
- VFP: VFP_LINES blank lines. On the final slot of VFP:
  - frame_count increments;
  - if enable=1, go straight to VSYNC (back-to-back frames, new frame_start, shadows re-latched);
  - otherwise go to IDLE with busy=0.
- Deasserting enable mid-frame has no effect; the current frame always completes.
- Patterns, with x = pixel index 0..H_ACTIVE-1 and y = active line 0..V_ACTIVE-1:
  - 0, color bars: bar = x / (H_ACTIVE/8). Colors in bar order: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
  - 1, gradient: g = x*32/H_ACTIVE (5 bits). Pixel = {g, g, 1'b0, g}, i.e. R=g, G={g,0}, B=g.
  - 2, counter: pixel = (x + y*H_ACTIVE) mod 2^16. It restarts at 0 each frame.
  - 3, solid: pixel = latched solid_color.
- Reset asserted mid-frame: all outputs return to reset values immediately (asynchronous). Generation resumes from IDLE after release.

Test Plan:
- Small params (H_ACTIVE=8, H_BLANK=2, V_ACTIVE=4, VSYNC=1, VBP=1, VFP=1), enable=1, pattern 0 → per line, 16 href-high slots (32 clk25) then 4 low slots. Byte sequence FF,FF,FF,E0,07,FF,07,E0,F8,1F,F8,00,00,1F,00,00. Frame period = 7 lines × 20 slots = 280 clk25. frame_count increments once per 280 cycles.
- Timing check → vsync high exactly 40 clk25. First href rises 80 clk25 after vsync rise. cam_d/href/vsync never change while cam_pclk=1.
- Pattern 2, small params → line 3 bytes are 00,18,00,19,…,00,1F. Second frame restarts at 00,00.
- Pattern 3, solid_color=0xABCD latched; change to 0x1234 mid-frame → whole frame shows AB,CD. The next frame shows 12,34.
- Drop enable during ACTIVE → current frame finishes, frame_count +1, busy falls at end of VFP. No further vsync. frame_start pulses exactly once.
- Assert rst_n=0 during ACTIVE → all outputs 0 asynchronously, frame_count=0. Release with enable=1 → vsync rises on the first slot.

Source files
------------

// File: rtl/ov7670_stream_gen.sv
// ---------------------------------------------------------------------------
// ov7670_stream_gen
//
// Emulates the camera side of an OV7670 pixel bus so the capture -> core ->
// VGA chain can be brought up without a physical sensor. Frames are RGB565,
// sent as two bytes per pixel (high byte first), with VSYNC/HREF framing.
// Everything runs in the clk25 domain. The emulated PCLK is clk25/2.
//
// Ports:
//   clk25        in   system clock (25 MHz)
//   rst_n        in   asynchronous active-low reset
//   enable       in   frame request, only looked at on frame boundaries
//   pattern_sel  in   0 colour bars, 1 gradient, 2 x+y counter, 3 solid
//   solid_color  in   RGB565 colour used by pattern 3
//   cam_pclk     out  emulated pixel clock, free-running after reset
//   cam_vsync    out  frame sync, active high
//   cam_href     out  line valid, active high
//   cam_d        out  pixel byte (0x00 whenever HREF is low)
//   frame_start  out  one clk25 pulse on the edge where VSYNC rises
//   busy         out  high from VSYNC rise until the end of the front porch
//   frame_count  out  number of completed frames, wraps at 0xFFFF
// ---------------------------------------------------------------------------
module ov7670_stream_gen #(
  parameter int H_ACTIVE    = 640,
  parameter int H_BLANK     = 144,
  parameter int V_ACTIVE    = 480,
  parameter int VSYNC_LINES = 3,
  parameter int VBP_LINES   = 17,
  parameter int VFP_LINES   = 10
) (
  input  logic        clk25,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic [15:0] solid_color,
  output logic        cam_pclk,
  output logic        cam_vsync,
  output logic        cam_href,
  output logic [7:0]  cam_d,
  output logic        frame_start,
  output logic        busy,
  output logic [15:0] frame_count
);

  localparam int LINE_SLOTS = 2 * (H_ACTIVE + H_BLANK);
  localparam int HW         = $clog2(LINE_SLOTS);
  localparam int XW         = $clog2(H_ACTIVE);
  localparam int LW         = $clog2(V_ACTIVE + VSYNC_LINES + VBP_LINES + VFP_LINES + 1);
  localparam int BAR_W      = H_ACTIVE / 8;

  localparam logic [HW-1:0] H_LAST    = HW'(LINE_SLOTS - 1);
  localparam logic [HW:0]   HREF_END  = (HW + 1)'(2 * H_ACTIVE);
  localparam logic [LW-1:0] VS_LAST   = LW'(VSYNC_LINES - 1);
  localparam logic [LW-1:0] VBP_LAST  = LW'(VBP_LINES - 1);
  localparam logic [LW-1:0] VA_LAST   = LW'(V_ACTIVE - 1);
  localparam logic [LW-1:0] VFP_LAST  = LW'(VFP_LINES - 1);

  typedef enum logic [2:0] {
    IDLE,
    VSYNC,
    VBP,
    ACTIVE,
    VFP
  } state_e;

  state_e        state_q, state_d;
  logic          pclk_q;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [LW-1:0] lcnt_q, lcnt_d;
  logic [15:0]   line_base_q, line_base_d;
  logic [1:0]    pat_q, pat_d;
  logic [15:0]   solid_q, solid_d;
  logic [15:0]   fcount_q, fcount_d;
  logic          vsync_q, vsync_d;
  logic          href_q, href_d;
  logic [7:0]    data_q, data_d;
  logic          busy_q, busy_d;
  logic          fstart_q;
  logic          start_frame;
  logic          line_end;
  logic          slot;

  logic [XW-1:0] pix_x;
  logic [2:0]    bar;
  logic [4:0]    grad;
  logic [15:0]   pixel;

  // A slot is the clk25 edge on which PCLK falls, i.e. whenever PCLK is
  // currently high. Every registered output except PCLK itself (and the
  // one-cycle frame_start pulse) only moves on slots.
  assign slot     = pclk_q;
  assign line_end = (hcnt_q == H_LAST);

  // Next-state logic: frame sequencing, slot/line counters and the per-frame
  // shadow registers. start_frame covers both the IDLE launch and the
  // back-to-back launch at the end of the front porch.
  always_comb begin
    state_d     = state_q;
    hcnt_d      = hcnt_q;
    lcnt_d      = lcnt_q;
    line_base_d = line_base_q;
    pat_d       = pat_q;
    solid_d     = solid_q;
    fcount_d    = fcount_q;
    start_frame = 1'b0;

    if (state_q != IDLE) begin
      hcnt_d = line_end ? '0 : hcnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (enable) begin
          start_frame = 1'b1;
        end
      end
      VSYNC: begin
        if (line_end) begin
          if (lcnt_q == VS_LAST) begin
            state_d = VBP;
            lcnt_d  = '0;
          end else begin
            lcnt_d = lcnt_q + 1'b1;
          end
        end
      end
      VBP: begin
        if (line_end) begin
          if (lcnt_q == VBP_LAST) begin
            state_d     = ACTIVE;
            lcnt_d      = '0;
            line_base_d = '0;
          end else begin
            lcnt_d = lcnt_q + 1'b1;
          end
        end
      end
      ACTIVE: begin
        if (line_end) begin
          // Running y*H_ACTIVE so the counter pattern needs no multiplier.
          line_base_d = line_base_q + 16'(H_ACTIVE);
          if (lcnt_q == VA_LAST) begin
            state_d = VFP;
            lcnt_d  = '0;
          end else begin
            lcnt_d = lcnt_q + 1'b1;
          end
        end
      end
      VFP: begin
        if (line_end) begin
          if (lcnt_q == VFP_LAST) begin
            fcount_d = fcount_q + 16'd1;
            lcnt_d   = '0;
            if (enable) begin
              start_frame = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            lcnt_d = lcnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (start_frame) begin
      state_d = VSYNC;
      hcnt_d  = '0;
      lcnt_d  = '0;
      pat_d   = pattern_sel;
      solid_d = solid_color;
    end
  end

  // Pixel generator. It works from the next-slot position so the byte is
  // registered together with HREF on the same slot.
  always_comb begin
    pix_x = hcnt_d[XW:1];
    bar   = 3'(int'(pix_x) / BAR_W);
    grad  = 5'((int'(pix_x) * 32) / H_ACTIVE);
    pixel = 16'h0000;
    case (pat_q)
      2'd0: begin
        case (bar)
          3'd0:    pixel = 16'hFFFF;
          3'd1:    pixel = 16'hFFE0;
          3'd2:    pixel = 16'h07FF;
          3'd3:    pixel = 16'h07E0;
          3'd4:    pixel = 16'hF81F;
          3'd5:    pixel = 16'hF800;
          3'd6:    pixel = 16'h001F;
          default: pixel = 16'h0000;
        endcase
      end
      2'd1:    pixel = {grad, grad, 1'b0, grad};
      2'd2:    pixel = line_base_d + 16'(pix_x);
      default: pixel = solid_q;
    endcase
  end

  // Output decode from the next state, so outputs are registered and aligned
  // with the state they describe.
  always_comb begin
    vsync_d = (state_d == VSYNC);
    href_d  = (state_d == ACTIVE) && ({1'b0, hcnt_d} < HREF_END);
    busy_d  = (state_d != IDLE);
    data_d  = 8'h00;
    if (href_d) begin
      data_d = hcnt_d[0] ? pixel[7:0] : pixel[15:8];
    end
  end

  // PCLK toggles every cycle; everything else is committed on slots only.
  // frame_start is cleared on every edge so it is exactly one clk25 wide.
  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      pclk_q      <= 1'b0;
      state_q     <= IDLE;
      hcnt_q      <= '0;
      lcnt_q      <= '0;
      line_base_q <= '0;
      pat_q       <= '0;
      solid_q     <= '0;
      fcount_q    <= '0;
      vsync_q     <= 1'b0;
      href_q      <= 1'b0;
      data_q      <= 8'h00;
      busy_q      <= 1'b0;
      fstart_q    <= 1'b0;
    end else begin
      pclk_q   <= ~pclk_q;
      fstart_q <= 1'b0;
      if (slot) begin
        state_q     <= state_d;
        hcnt_q      <= hcnt_d;
        lcnt_q      <= lcnt_d;
        line_base_q <= line_base_d;
        pat_q       <= pat_d;
        solid_q     <= solid_d;
        fcount_q    <= fcount_d;
        vsync_q     <= vsync_d;
        href_q      <= href_d;
        data_q      <= data_d;
        busy_q      <= busy_d;
        fstart_q    <= start_frame;
      end
    end
  end

  assign cam_pclk    = pclk_q;
  assign cam_vsync   = vsync_q;
  assign cam_href    = href_q;
  assign cam_d       = data_q;
  assign frame_start = fstart_q;
  assign busy        = busy_q;
  assign frame_count = fcount_q;

endmodule
